// File: rtl/sram_pb_scrub_ctrl.sv
// Single owner of a parity-protected 1R1W SRAM: client pass-through with priority, background scrubber, error log.
// Define SRAM_SCRUB_REPAIR_EN to make the scrubber rewrite faulty entries with zero.
module sram_pb_scrub_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE           = 1024,
    parameter int SCRUB_INTERVAL = 256,
    parameter int ADDR_WIDTH     = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  client_read_en,
    input  logic [ADDR_WIDTH-1:0] client_read_addr,
    input  logic                  client_write_en,
    input  logic [ADDR_WIDTH-1:0] client_write_addr,
    input  logic [DATA_WIDTH-1:0] client_write_data,
    output logic [DATA_WIDTH-1:0] client_read_data,
    output logic                  client_read_valid,
    output logic                  client_read_error,
    output logic                  sram_read_en,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    input  logic                  sram_ecc_pb_error,
    input  logic                  scrub_enable,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] last_err_addr,
    output logic                  err_irq,
    output logic                  scrub_pass_done
);

    localparam int                    CNT_W     = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SIZE - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SCRUB_READ,
        S_CHECK
`ifdef SRAM_SCRUB_REPAIR_EN
        , S_REPAIR
`endif
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   scrub_addr_q;
    logic                    pass_done_q;
    logic                    rd_valid_q;
    logic                    rd_error_q;
    logic                    err_irq_q;
    logic [15:0]             err_count_q;
    logic [ADDR_WIDTH-1:0]   last_err_addr_q;

    logic                    same_addr;
    logic                    rd_err;
    logic                    advance;

    assign sram_read_en   = client_read_en || (state_q == S_SCRUB_READ);
    assign sram_read_addr = client_read_en ? client_read_addr : scrub_addr_q;

`ifdef SRAM_SCRUB_REPAIR_EN
    logic scrub_err_q;
    logic client_write_hit;
    logic scrub_rd;

    assign scrub_rd         = (state_q == S_SCRUB_READ) && !client_read_en;
    assign client_write_hit = client_write_en && (client_write_addr == scrub_addr_q);
    assign sram_write_en    = client_write_en || (state_q == S_REPAIR);
    assign sram_write_addr  = client_write_en ? client_write_addr : scrub_addr_q;
    assign sram_write_data  = client_write_en ? client_write_data : '0;

    // A client write to the entry under repair already restores good parity, so the repair is dropped.
    assign advance = ((state_q == S_CHECK) && !(scrub_err_q && !client_write_hit)) ||
                     ((state_q == S_REPAIR) && (!client_write_en || client_write_hit));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scrub_err_q <= 1'b0;
        end else begin
            scrub_err_q <= scrub_rd && rd_err;
        end
    end
`else
    assign sram_write_en   = client_write_en;
    assign sram_write_addr = client_write_addr;
    assign sram_write_data = client_write_data;
    assign advance         = (state_q == S_CHECK);
`endif

    // Same-address write: the SRAM forwards the new word, so the old array's parity verdict is meaningless.
    assign same_addr = sram_write_en && sram_read_en && (sram_write_addr == sram_read_addr);
    assign rd_err    = sram_read_en && sram_ecc_pb_error && !same_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            scrub_addr_q <= '0;
            pass_done_q  <= 1'b0;
        end else begin
            pass_done_q <= 1'b0;
            if (advance) begin
                scrub_addr_q <= scrub_addr_q + ADDR_WIDTH'(1);
                pass_done_q  <= (scrub_addr_q == ADDR_LAST);
                state_q      <= S_WAIT;
            end else begin
                case (state_q)
                    S_WAIT: begin
                        if (scrub_enable) begin
                            if (cnt_q == CNT_LAST) begin
                                cnt_q   <= '0;
                                state_q <= S_SCRUB_READ;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    S_SCRUB_READ: begin
                        if (!client_read_en) state_q <= S_CHECK;
                    end
`ifdef SRAM_SCRUB_REPAIR_EN
                    S_CHECK: state_q <= S_REPAIR;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q      <= 1'b0;
            rd_error_q      <= 1'b0;
            err_irq_q       <= 1'b0;
            err_count_q     <= '0;
            last_err_addr_q <= '0;
        end else begin
            rd_valid_q <= client_read_en;
            rd_error_q <= client_read_en && rd_err;
            err_irq_q  <= rd_err;
            if (rd_err) begin
                err_count_q     <= sat_inc16(err_count_q);
                last_err_addr_q <= sram_read_addr;
            end
        end
    end

    // SRAM read data is already registered; gate it so the bus stays quiet outside valid cycles.
    assign client_read_data  = rd_valid_q ? sram_read_data : '0;
    assign client_read_valid = rd_valid_q;
    assign client_read_error = rd_error_q;
    assign err_irq           = err_irq_q;
    assign err_count         = err_count_q;
    assign last_err_addr     = last_err_addr_q;
    assign scrub_pass_done   = pass_done_q;

endmodule

// File: tb/tb_sram_pb_scrub_ctrl.sv
// Directed + randomized bench for sram_pb_scrub_ctrl with an SRAM model and a behavioural expectation model.
module tb_sram_pb_scrub_ctrl;
    localparam int DW = 32;
    localparam int N  = 16;
    localparam int SI = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          client_read_en;
    logic [AW-1:0] client_read_addr;
    logic          client_write_en;
    logic [AW-1:0] client_write_addr;
    logic [DW-1:0] client_write_data;
    logic [DW-1:0] client_read_data;
    logic          client_read_valid;
    logic          client_read_error;
    logic          sram_read_en;
    logic [AW-1:0] sram_read_addr;
    logic          sram_write_en;
    logic [AW-1:0] sram_write_addr;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_read_data;
    logic          sram_ecc_pb_error;
    logic          scrub_enable;
    logic [15:0]   err_count;
    logic [AW-1:0] last_err_addr;
    logic          err_irq;
    logic          scrub_pass_done;

    sram_pb_scrub_ctrl #(.DATA_WIDTH(DW), .SIZE(N), .SCRUB_INTERVAL(SI)) dut (
        .clk(clk), .reset_n(reset_n),
        .client_read_en(client_read_en), .client_read_addr(client_read_addr),
        .client_write_en(client_write_en), .client_write_addr(client_write_addr),
        .client_write_data(client_write_data),
        .client_read_data(client_read_data), .client_read_valid(client_read_valid),
        .client_read_error(client_read_error),
        .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr),
        .sram_write_en(sram_write_en), .sram_write_addr(sram_write_addr),
        .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data), .sram_ecc_pb_error(sram_ecc_pb_error),
        .scrub_enable(scrub_enable),
        .err_count(err_count), .last_err_addr(last_err_addr),
        .err_irq(err_irq), .scrub_pass_done(scrub_pass_done)
    );

    // SRAM model: registered read, write-to-read bypass, combinational parity flag from stored state.
    bit [DW-1:0]   mem [N];
    bit            bad [N];
    logic [DW-1:0] rdata_q = '0;
    logic          corrupt_en;
    logic [AW-1:0] corrupt_addr;

    always @(posedge clk) begin
        if (sram_write_en) begin
            mem[sram_write_addr] <= sram_write_data;
            bad[sram_write_addr] <= 1'b0;
        end
        if (corrupt_en) bad[corrupt_addr] <= 1'b1;
        if (sram_read_en)
            rdata_q <= (sram_write_en && sram_write_addr == sram_read_addr) ? sram_write_data : mem[sram_read_addr];
    end
    assign sram_read_data    = rdata_q;
    assign sram_ecc_pb_error = sram_read_en && bad[sram_read_addr];

    // Observers of DUT-side activity.
    int            cyc = 0;
    logic [AW-1:0] scrub_addrs [$];
    int            scrub_cyc [$];
    int            irq_seen = 0;
    int            pass_seen = 0;
    int            rep_seen = 0;
    logic [AW-1:0] rep_addr = '0;
    logic [DW-1:0] rep_data = '1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (sram_read_en && !client_read_en) begin
            scrub_addrs.push_back(sram_read_addr);
            scrub_cyc.push_back(cyc);
        end
        if (err_irq) irq_seen <= irq_seen + 1;
        if (scrub_pass_done) pass_seen <= pass_seen + 1;
        if (sram_write_en && !client_write_en) begin
            rep_seen <= rep_seen + 1;
            rep_addr <= sram_write_addr;
            rep_data <= sram_write_data;
        end
    end

    // Expectation model.
    bit [DW-1:0]   ref_mem [N];
    bit            ref_bad [N];
    int            ref_cnt = 0;
    logic [AW-1:0] ref_last = '0;
    int            ref_irq = 0;
    int            ref_rep = 0;
`ifdef SRAM_SCRUB_REPAIR_EN
    localparam bit REPAIR = 1'b1;
`else
    localparam bit REPAIR = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic client_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        client_write_en = 1'b1; client_write_addr = a; client_write_data = d;
        tick();
        client_write_en = 1'b0;
        ref_mem[a] = d;
        ref_bad[a] = 1'b0;
    endtask

    task automatic client_read_check(input string tag, input logic [AW-1:0] a);
        client_read_en = 1'b1; client_read_addr = a;
        tick();
        client_read_en = 1'b0;
        if (ref_bad[a]) begin
            ref_cnt  = ref_cnt + 1;
            ref_last = a;
            ref_irq  = ref_irq + 1;
        end
        check({tag, "_valid"}, client_read_valid, 1);
        check({tag, "_data"}, client_read_data, ref_mem[a]);
        check({tag, "_error"}, client_read_error, ref_bad[a]);
        check({tag, "_irq"}, err_irq, ref_bad[a]);
        check({tag, "_count"}, err_count, ref_cnt);
        check({tag, "_last"}, last_err_addr, ref_last);
    endtask

    task automatic wait_scrub(input string tag, input logic [AW-1:0] a, input int start);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (scrub_addrs.size() > start && scrub_addrs[scrub_addrs.size()-1] == a) found = 1'b1;
        end
        check({tag, "_reached"}, found, 1);
    endtask

    task automatic corrupt(input logic [AW-1:0] a);
        corrupt_en = 1'b1; corrupt_addr = a;
        tick();
        corrupt_en = 1'b0;
        ref_bad[a] = 1'b1;
    endtask

    initial begin
        int nbad, nbad2, start;
        bit found;
        logic [DW-1:0] d;

        reset_n = 1'b0; client_read_en = 1'b0; client_read_addr = '0;
        client_write_en = 1'b0; client_write_addr = '0; client_write_data = '0;
        scrub_enable = 1'b1; corrupt_en = 1'b0; corrupt_addr = '0;
        tick(); tick();
        check("rst_valid", client_read_valid, 0);
        check("rst_error", client_read_error, 0);
        check("rst_data", client_read_data, 0);
        check("rst_count", err_count, 0);
        check("rst_last", last_err_addr, 0);
        check("rst_irq", err_irq, 0);
        check("rst_pass", scrub_pass_done, 0);
        check("rst_sram_re", sram_read_en, 0);
        check("rst_sram_we", sram_write_en, 0);

        // Full scrub pass with no client traffic.
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (scrub_pass_done) found = 1'b1;
        end
        scrub_enable = 1'b0;
        check("pass_reached", found, 1);
        check("pass_reads", scrub_addrs.size(), N);
        nbad = 0; nbad2 = 0;
        for (int i = 0; i < scrub_addrs.size(); i++) begin
            if (scrub_addrs[i] != AW'(i)) nbad++;
            if (i > 0 && scrub_cyc[i] - scrub_cyc[i-1] != SI + 2) nbad2++;
        end
        check("pass_order", nbad, 0);
        check("pass_period", nbad2, 0);
        tick();
        check("pass_pulse_len", scrub_pass_done, 0);
        tick(); tick();
        check("pass_count", pass_seen, 1);
        check("pass_errs", err_count, 0);

        // Basic client write then read.
        client_write(5, 32'hA5A5A5A5);
        client_read_check("rd5", 5);

        // Randomized client traffic, concurrent reads and writes.
        nbad = 0;
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] ra, wa;
            logic [DW-1:0] wd, exp_d;
            bit re, we;
            re = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            ra = AW'($urandom_range(0, N-1)); wa = AW'($urandom_range(0, N-1)); wd = $urandom;
            client_read_en = re; client_read_addr = ra;
            client_write_en = we; client_write_addr = wa; client_write_data = wd;
            exp_d = (we && wa == ra) ? wd : ref_mem[ra];
            tick();
            client_read_en = 1'b0; client_write_en = 1'b0;
            if (we) begin ref_mem[wa] = wd; ref_bad[wa] = 1'b0; end
            if (client_read_valid !== re) nbad++;
            if (re && (client_read_data !== exp_d || client_read_error !== 1'b0)) nbad++;
        end
        check("rand_traffic", nbad, 0);
        check("rand_errs", err_count, 0);

        // Client read of a corrupted entry.
        corrupt(3);
        client_read_check("bad3", 3);
        tick();
        check("bad3_irq_pulse", err_irq, 0);

        // Scrubber finds the same corruption.
        start = scrub_addrs.size();
        scrub_enable = 1'b1;
        wait_scrub("scrub3", 3, start);
        scrub_enable = 1'b0;
        ref_cnt = ref_cnt + 1; ref_last = 3; ref_irq = ref_irq + 1;
        check("scrub3_irq", err_irq, 1);
        check("scrub3_count", err_count, ref_cnt);
        check("scrub3_last", last_err_addr, ref_last);
        tick(); tick(); tick(); tick();
        if (REPAIR) begin
            ref_rep = ref_rep + 1; ref_mem[3] = '0; ref_bad[3] = 1'b0;
            check("repair_addr", rep_addr, 3);
            check("repair_data", rep_data, 0);
        end
        check("repair_writes", rep_seen, ref_rep);
        check("scrub3_irqs", irq_seen, ref_irq);
        client_read_check("reread3", 3);

        // Client reads hold the scrubber in SCRUB_READ indefinitely.
        start = scrub_addrs.size();
        scrub_enable = 1'b1;
        client_read_en = 1'b1; client_read_addr = 9;
        nbad = 0; nbad2 = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sram_read_en !== 1'b1 || sram_read_addr !== 4'd9) nbad++;
            if (client_read_valid !== 1'b1 || client_read_data !== ref_mem[9]) nbad2++;
        end
        check("stall_port", nbad, 0);
        check("stall_client", nbad2, 0);
        check("stall_no_scrub", scrub_addrs.size(), start);
        client_read_en = 1'b0;
        #1;
        check("resume_re", sram_read_en, 1);
        check("resume_addr", sram_read_addr, 4);
        tick();
        scrub_enable = 1'b0;
        tick(); tick(); tick();
        check("resume_logged", scrub_addrs.size(), start + 1);

        // Scrub read of a bad entry coinciding with a client write to it.
        corrupt(7);
        start = scrub_addrs.size();
        scrub_enable = 1'b1;
        wait_scrub("to6", 6, start);
        client_read_en = 1'b1; client_read_addr = 9;
        for (int i = 0; i < 12; i++) tick();
        start = scrub_addrs.size();
        d = $urandom;
        client_read_en = 1'b0;
        client_write_en = 1'b1; client_write_addr = 7; client_write_data = d;
        #1;
        check("same_rd_addr", sram_read_addr, 7);
        tick();
        client_write_en = 1'b0;
        scrub_enable = 1'b0;
        ref_mem[7] = d; ref_bad[7] = 1'b0;
        tick(); tick(); tick();
        check("same_scrubbed", scrub_addrs.size(), start + 1);
        check("same_count", err_count, ref_cnt);
        check("same_irqs", irq_seen, ref_irq);
        check("same_repairs", rep_seen, ref_rep);
        client_read_check("rd7", 7);

        // Reset in the middle of scrubbing restarts from address 0.
        scrub_enable = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        reset_n = 1'b0;
        #1;
        ref_cnt = 0; ref_last = '0;
        check("mid_rst_count", err_count, 0);
        check("mid_rst_last", last_err_addr, 0);
        check("mid_rst_re", sram_read_en, 0);
        tick();
        reset_n = 1'b1;
        start = scrub_addrs.size();
        wait_scrub("restart", 0, start);
        check("restart_first", scrub_addrs.size(), start + 1);
        scrub_enable = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
